// File: rtl/operand_entry_pkg.sv
// Shared types and default timing constants for the operand_entry capture stage.
package operand_entry_pkg;

    typedef enum logic {
        ST_WAIT_A = 1'b0,
        ST_WAIT_B = 1'b1
    } entry_state_t;

    // 20 ms debounce and 5 s idle limit at a 12 MHz clock
    localparam int DEBOUNCE_CYCLES_DEF = 240000;
    localparam int TIMEOUT_CYCLES_DEF  = 60000000;

endpackage

// File: rtl/operand_entry_btn_debounce.sv
// Push-button front end: 2-FF synchroniser, level debouncer and a one-cycle
// press_evt pulse on each debounced 1->0 (press) transition.
module btn_debounce
    import operand_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic press_evt
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end

    logic             sync_meta_r;
    logic             sync_r;
    logic             db_r;
    logic [CNT_W-1:0] cnt_r;
    logic             differ_s;
    logic             done_s;

    // Detect disagreement with the debounced level and the end of the stable run
    always_comb begin
        differ_s = sync_r ^ db_r;
        done_s   = differ_s && (cnt_r == CNT_LAST);
    end

    // Synchroniser, stability counter, debounced level and press pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta_r <= 1'b1;
            sync_r      <= 1'b1;
            db_r        <= 1'b1;
            cnt_r       <= '0;
            press_evt   <= 1'b0;
        end else begin
            sync_meta_r <= button;
            sync_r      <= sync_meta_r;
            press_evt   <= done_s && db_r;
            if (!differ_s) begin
                cnt_r <= '0;
            end else if (done_s) begin
                cnt_r <= '0;
                db_r  <= ~db_r;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/operand_entry.sv
// Operand capture for the switch adder: press 1 latches A, press 2 latches B.
// Optional WAIT_B idle timeout is enabled by defining OPERAND_ENTRY_TIMEOUT_EN.
module operand_entry
    import operand_entry_pkg::*;
#(
    parameter int DATA_W          = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] num,
    input  logic              button,
    output logic [DATA_W-1:0] cur_num,
    output logic [DATA_W-1:0] add_num,
    output logic              entry_phase,
    output logic              load_pulse,
    output logic              sum_valid
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    logic [DATA_W-1:0] num_meta_r;
    logic [DATA_W-1:0] num_sync_r;
    logic              press_evt_s;
    logic              to_hit_s;
    entry_state_t      state_r;
    entry_state_t      state_nxt_s;
    logic [DATA_W-1:0] cur_nxt_s;
    logic [DATA_W-1:0] add_nxt_s;
    logic              sum_valid_nxt_s;
    logic              load_nxt_s;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk      (clk),
        .rst      (rst),
        .button   (button),
        .press_evt(press_evt_s)
    );

    // Switch bus synchroniser
    always_ff @(posedge clk) begin
        if (rst) begin
            num_meta_r <= '0;
            num_sync_r <= '0;
        end else begin
            num_meta_r <= num;
            num_sync_r <= num_meta_r;
        end
    end

`ifdef OPERAND_ENTRY_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_r;

    always_comb begin
        to_hit_s = (state_r == ST_WAIT_B) && (to_cnt_r == TO_LAST);
    end

    // Idle counter runs only while staying in WAIT_B
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_r <= '0;
        end else if ((state_r != ST_WAIT_B) || (state_nxt_s != ST_WAIT_B)) begin
            to_cnt_r <= '0;
        end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end
    end
`else
    always_comb begin
        to_hit_s = 1'b0;
    end
`endif

    // Sequencer next state and operand register updates; a press beats a timeout
    always_comb begin
        state_nxt_s     = state_r;
        cur_nxt_s       = cur_num;
        add_nxt_s       = add_num;
        sum_valid_nxt_s = sum_valid;
        load_nxt_s      = 1'b0;
        case (state_r)
            ST_WAIT_A: begin
                if (press_evt_s) begin
                    cur_nxt_s       = num_sync_r;
                    sum_valid_nxt_s = 1'b0;
                    load_nxt_s      = 1'b1;
                    state_nxt_s     = ST_WAIT_B;
                end else begin
                    state_nxt_s = ST_WAIT_A;
                end
            end
            ST_WAIT_B: begin
                if (press_evt_s) begin
                    add_nxt_s       = num_sync_r;
                    sum_valid_nxt_s = 1'b1;
                    load_nxt_s      = 1'b1;
                    state_nxt_s     = ST_WAIT_A;
                end else if (to_hit_s) begin
                    cur_nxt_s   = '0;
                    state_nxt_s = ST_WAIT_A;
                end else begin
                    state_nxt_s = ST_WAIT_B;
                end
            end
            default: begin
                state_nxt_s = ST_WAIT_A;
            end
        endcase
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_WAIT_A;
            cur_num    <= '0;
            add_num    <= '0;
            sum_valid  <= 1'b0;
            load_pulse <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cur_num    <= cur_nxt_s;
            add_num    <= add_nxt_s;
            sum_valid  <= sum_valid_nxt_s;
            load_pulse <= load_nxt_s;
        end
    end

    assign entry_phase = (state_r == ST_WAIT_B);

endmodule

// File: doc/operand_entry.md
# operand_entry

Front-end operand capture stage for the 4-bit switch adder. It synchronises the 4-bit switch bus and the raw push-button, then debounces the button. A two-state sequencer latches the switch value as the first operand on one press and as the second operand on the next. The outputs `cur_num`/`add_num` drive the adder inputs directly, and `sum_valid` marks when both operands belong to the same entry pair.

## Interface
- `DATA_W`, default 4: operand width.
- `DEBOUNCE_CYCLES`, default 240000: consecutive stable cycles needed to accept a button level change (20 ms at 12 MHz). Minimum 2.
- `TIMEOUT_CYCLES`, default 60000000: idle limit while waiting for operand B. Used only with `OPERAND_ENTRY_TIMEOUT_EN`.
- `clk`, in, 1: system clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous reset, active-high.
- `num`, in, DATA_W: raw switch inputs, asynchronous.
- `button`, in, 1: raw push-button, asynchronous, active-low (pressed = 0).
- `cur_num`, out, DATA_W: first operand (A).
- `add_num`, out, DATA_W: second operand (B).
- `entry_phase`, out, 1: 0 = next press loads A; 1 = next press loads B.
- `load_pulse`, out, 1: one-cycle strobe on every operand capture.
- `sum_valid`, out, 1: high while A and B come from the same entry pair.

## Operation
- **Synchronisers:** `button` and `num` each pass through a 2-FF synchroniser.
- **Debouncer:**
  - Holds a debounced level `db`, reset value 1 (released).
  - A counter increments while the synchronised button differs from `db`, and clears to 0 when they match.
  - When the counter reaches `DEBOUNCE_CYCLES-1` while still differing, `db` toggles and the counter clears.
  - A press event is `db` going 1→0. Releases produce no event.
- **Sequencer states:**
  - WAIT_A (`entry_phase`=0) → press: `cur_num` ← synchronised `num`, `sum_valid` ← 0, go to WAIT_B.
  - WAIT_B (`entry_phase`=1) → press: `add_num` ← synchronised `num`, `sum_valid` ← 1, go to WAIT_A.
- **Retention:** `add_num` keeps its value across a new A capture; only `sum_valid` drops.
- **Load strobe:** `load_pulse` is 1 in the cycle following each capture edge, i.e. concurrent with the new register value.
- **No arithmetic:** the switch value is captured verbatim at full DATA_W.
- **Reset values:** `cur_num`=0, `add_num`=0, `entry_phase`=0, `load_pulse`=0, `sum_valid`=0. Debounce counter=0, `db`=1, synchroniser flops=1 (button) and 0 (num).

## Timing
- **Capture latency:** `button` falls and is held low before rising edge E0. The operand register updates on edge E0+DEBOUNCE_CYCLES+2 (2 sync + DEBOUNCE_CYCLES count + 1 capture, minus overlap of the final count edge). `load_pulse` is high for the cycle after that edge.
- **Switch sampling:** `num` is sampled through its synchroniser at the capture edge. The value must be stable at least 2 cycles before that edge.
- **Glitches:** any bounce that returns to `db` before the count completes clears the counter, and no event occurs.
- **Repeat presses:** at most one event per press. The next event needs a debounced release (DEBOUNCE_CYCLES high) followed by a new debounced press.
- **Button held through reset release:** `db` starts at 1, so after DEBOUNCE_CYCLES of low this registers as a press and loads A.
- **`rst` mid-count or mid-entry:** everything returns to its reset value on that edge, and any partial entry is discarded.
- **`rst` and a press in the same cycle:** reset wins, and the event is lost.

## Configuration
- **`OPERAND_ENTRY_TIMEOUT_EN` defined:**
  - A counter runs while in WAIT_B and clears on leaving it.
  - If it reaches `TIMEOUT_CYCLES-1` with no press, the state returns to WAIT_A and `cur_num` is cleared to 0.
  - `add_num`, `sum_valid` and `load_pulse` do not change.
  - If a press and the timeout fall on the same edge, the press wins.
- **Not defined:** WAIT_B waits indefinitely, and no timeout counter is synthesised.

## Structure
- **Shared package `operand_entry_pkg`:**
  - state enum (`ST_WAIT_A`, `ST_WAIT_B`);
  - default constants `DEBOUNCE_CYCLES_DEF`, `TIMEOUT_CYCLES_DEF`.
- **Sub-module `btn_debounce`:**
  - contains the 2-FF sync, the counter and `db`;
  - outputs `press_evt` (1-cycle pulse);
  - parameterised by `DEBOUNCE_CYCLES`.
- **Top level:** the switch synchroniser, sequencer and optional timeout live in `operand_entry`.

## Test plan
Benches use `DEBOUNCE_CYCLES`=8 and `TIMEOUT_CYCLES`=50.
- **Reset:** assert `rst` 3 cycles with `button`=1 → all outputs 0, `entry_phase`=0.
- **Two clean presses:** `num`=4'h5, press held 20 cycles, release 20 cycles; then `num`=4'h3, press again → `cur_num`=5, then `add_num`=3. Two `load_pulse`s; `sum_valid`=1 after the second; capture exactly DEBOUNCE_CYCLES+2 edges after each fall.
- **Bounce:** pattern 0,1,0,0,1 (each shorter than 8 cycles), then stable low 8 cycles → exactly one capture, `entry_phase` 0→1.
- **Third press:** after A=5, B=3, press with `num`=4'hA → `cur_num`=A, `add_num` stays 3, `sum_valid`=0, `entry_phase`=1.
- **Reset mid-entry:** `rst` pulse after A is captured → all outputs return to 0. The next press loads A, not B.
- **Timeout (macro on):** capture A=7, no press for 50 cycles → `cur_num`=0, `entry_phase`=0, no `load_pulse`. With the macro off, the same stimulus keeps `entry_phase`=1.
